fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: word width, default
// reset fetch address and the fetch FSM state encoding.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] START_PC_DEF = 32'h8002_0000;
  localparam logic [WORD_W-1:0] WORD_INC = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with registered output and branch redirect.
// Build option: FETCH_DELAY_SLOT_EN keeps one delay-slot instruction across a redirect.
//
// state  | meaning
// S_REQ  | request fetch_pc when the output register is free or draining
// S_WAIT | one request granted, waiting for im_rvalid
// S_HOLD | instruction captured while stalled, held until stall drops
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] START_PC = START_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              do_branch,
  input  logic [WORD_W-1:0] pc_effective,
  output logic              im_req,
  output logic [WORD_W-1:0] im_addr,
  input  logic              im_gnt,
  input  logic              im_rvalid,
  input  logic [WORD_W-1:0] im_rdata,
  output logic              insn_valid,
  output logic [WORD_W-1:0] insn_out,
  output logic [WORD_W-1:0] pc_out
);

  fetch_state_t      state, state_nx;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] req_pc;
  logic [WORD_W-1:0] target;
  logic              squash;
  logic              squash_set;
  logic              gnt_fire;
  logic              rsp_fire;
  logic              capture;
  logic              consume;
  logic              kill;

  assign target   = word_align(pc_effective);
  assign gnt_fire = im_req & im_gnt;
  assign rsp_fire = (state == S_WAIT) & im_rvalid;
  assign consume  = insn_valid & ~stall;
  assign capture  = rsp_fire & ~squash & ~kill;

`ifdef FETCH_DELAY_SLOT_EN
  logic              redir_pend;
  logic [WORD_W-1:0] redir_pc;

  // The held instruction is the slot; anything requested alongside it is extra.
  assign kill       = 1'b0;
  assign squash_set = do_branch & insn_valid & gnt_fire;
`else
  assign kill       = do_branch;
  assign squash_set = do_branch & (((state == S_WAIT) & ~im_rvalid) | gnt_fire);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_REQ:   if (gnt_fire) state_nx = S_WAIT;
      S_WAIT:  if (rsp_fire) state_nx = (capture && stall) ? S_HOLD : S_REQ;
      S_HOLD:  if (!stall || kill) state_nx = S_REQ;
      default: state_nx = S_REQ;
    endcase
  end

  always_comb begin
    im_req  = 1'b0;
    im_addr = word_align(fetch_pc);
    if (state == S_REQ && !reset) im_req = ~insn_valid | ~stall;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= START_PC;
      req_pc     <= START_PC;
      squash     <= 1'b0;
      insn_valid <= 1'b0;
      insn_out   <= '0;
      pc_out     <= '0;
`ifdef FETCH_DELAY_SLOT_EN
      redir_pend <= 1'b0;
      redir_pc   <= START_PC;
`endif
    end else begin
      if (gnt_fire) req_pc <= fetch_pc;

      // Any response ends a squash; a redirect alongside it needs no new squash.
      if (rsp_fire)        squash <= 1'b0;
      else if (squash_set) squash <= 1'b1;

      if (capture) begin
        insn_out   <= im_rdata;
        pc_out     <= req_pc;
        insn_valid <= 1'b1;
      end else if (kill || consume) begin
        insn_valid <= 1'b0;
      end

`ifdef FETCH_DELAY_SLOT_EN
      if (capture) begin
        redir_pend <= 1'b0;
        if (do_branch)       fetch_pc <= target;
        else if (redir_pend) fetch_pc <= redir_pc;
        else                 fetch_pc <= req_pc + WORD_INC;
      end else if (do_branch) begin
        // With nothing held, the next instruction fetched is the slot.
        if (insn_valid) begin
          fetch_pc <= target;
        end else begin
          redir_pend <= 1'b1;
          redir_pc   <= target;
        end
      end
`else
      if (do_branch)    fetch_pc <= target;
      else if (capture) fetch_pc <= req_pc + WORD_INC;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected request addresses and delivered
// PCs are queued by the stimulus and popped by an independent monitor.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, stall, do_branch, im_gnt, im_rvalid;
  logic        im_req, insn_valid;
  logic [31:0] pc_effective, im_addr, im_rdata, insn_out, pc_out;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  int          rsp_lat = 0;
  int          max_gap = 0;

  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .do_branch(do_branch),
    .pc_effective(pc_effective), .im_req(im_req), .im_addr(im_addr),
    .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .insn_valid(insn_valid), .insn_out(insn_out), .pc_out(pc_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Memory model: answers each grant rsp_lat cycles after the earliest legal slot.
  initial begin
    pend = 1'b0; pend_addr = '0; pend_wait = 0;
    im_rvalid = 1'b0; im_rdata = '0;
    forever begin
      @(negedge clock);
      if (im_req && im_gnt) begin
        pend = 1'b1; pend_addr = im_addr; pend_wait = rsp_lat;
      end
      @(posedge clock); #2;
      im_rvalid = 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          im_rvalid = 1'b1; im_rdata = mem_word(pend_addr); pend = 1'b0;
        end else begin
          pend_wait--;
        end
      end
    end
  end

  // Monitor: grants and deliveries are judged on the values held before the edge.
  initial begin
    logic [31:0] e;
    logic        dropped;
    forever begin
      @(negedge clock);
`ifdef FETCH_DELAY_SLOT_EN
      dropped = 1'b0;
`else
      dropped = do_branch;
`endif
      if (!reset && im_req && im_gnt) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got addr %08h, no request expected", im_addr);
        end else begin
          check("im_addr", im_addr, exp_addr_q.pop_front());
        end
      end
      if (!reset && insn_valid && !stall && !dropped) begin
        if (exp_pc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_insn: got pc %08h, no delivery expected", pc_out);
        end else begin
          e = exp_pc_q.pop_front();
          check("pc_out", pc_out, e);
          check("insn_out", insn_out, mem_word(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic deliver);
    exp_addr_q.push_back(a);
    if (deliver) exp_pc_q.push_back(a);
  endtask

  // Grant n requests, then drop im_gnt just after the last grant edge.
  task automatic issue(input int n);
    int cnt = 0;
    int gap = 0;
    int bud = 0;
    im_gnt = 1'b1; max_gap = 0;
    while (cnt < n && bud < 200) begin
      @(negedge clock); bud++; gap++;
      if (im_req && im_gnt) begin
        cnt++;
        if (cnt > 1 && gap > max_gap) max_gap = gap;
        gap = 0;
      end
    end
    if (cnt < n) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: got %0d grants expected %0d", cnt, n);
    end
    tick(); im_gnt = 1'b0;
  endtask

  task automatic drain();
    int bud = 0;
    while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && bud < 100) begin
      @(negedge clock); bud++;
    end
    n_checks++;
    if (exp_addr_q.size() != 0 || exp_pc_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d addr / %0d insn pending expected 0 / 0",
               exp_addr_q.size(), exp_pc_q.size());
    end
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; do_branch = 1'b0; im_gnt = 1'b1; pc_effective = '0;
    tick();
    @(negedge clock);
    check("rst_im_req", im_req, 0);
    check("rst_insn_valid", insn_valid, 0);
    check("rst_insn_out", insn_out, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_im_addr", im_addr, 32'h8002_0000);
    tick(); im_gnt = 1'b0; reset = 1'b0;

    // Sequential fetch at best-case rate.
    push(32'h8002_0000, 1); push(32'h8002_0004, 1); push(32'h8002_0008, 1);
    issue(3);
    check("throughput_gap", max_gap, 2);
    drain();

    // Stall with 8002_0004 held.
    do_reset();
    push(32'h8002_0000, 1); push(32'h8002_0004, 1);
    issue(2);
    stall = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid", insn_valid, 1);
      check("hold_pc", pc_out, 32'h8002_0004);
      check("hold_insn", insn_out, mem_word(32'h8002_0004));
      check("hold_im_req", im_req, 0);
    end
    tick(); stall = 1'b0;
    push(32'h8002_0008, 1);
    issue(1);
    drain();

    // Redirect while waiting on 8002_0010.
    do_reset();
    push(32'h8002_0000, 1); push(32'h8002_0004, 1);
    push(32'h8002_0008, 1); push(32'h8002_000C, 1);
    issue(4);
    drain();
    rsp_lat = 2;
`ifdef FETCH_DELAY_SLOT_EN
    push(32'h8002_0010, 1);
`else
    push(32'h8002_0010, 0);
`endif
    issue(1);
    do_branch = 1'b1; pc_effective = 32'h8002_0103;
    tick();
    do_branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
`ifndef FETCH_DELAY_SLOT_EN
      check("squash_valid", insn_valid, 0);
`endif
    end
    rsp_lat = 0;
    tick();
    push(32'h8002_0100, 1);
    issue(1);
    drain();

    // Redirect to the top word, then sequential wrap to zero.
    do_branch = 1'b1; pc_effective = 32'hFFFF_FFFC;
    tick();
    do_branch = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    push(32'h8002_0104, 1);
    push(32'hFFFF_FFFC, 1); push(32'h0000_0000, 1);
    issue(3);
`else
    push(32'hFFFF_FFFC, 1); push(32'h0000_0000, 1);
    issue(2);
`endif
    drain();

    // Reset while a request is outstanding; its late response must be ignored.
    rsp_lat = 3;
    push(32'h0000_0004, 0);
    issue(1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_im_req", im_req, 0);
    check("mid_rst_valid", insn_valid, 0);
    check("mid_rst_insn_out", insn_out, 0);
    check("mid_rst_pc_out", pc_out, 0);
    check("mid_rst_im_addr", im_addr, 32'h8002_0000);
    tick(); reset = 1'b0; rsp_lat = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stale_valid", insn_valid, 0);
    end
    tick();
    push(32'h8002_0000, 1);
    issue(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
